// File: rtl/cc_gravity_if.sv
// Cell-stream bus for cc_gravity: board cells in, settled board cells out.
interface cc_gravity_if;
  logic       in_valid;
  logic [2:0] in_color;
  logic       in_ready;
  logic       out_valid;
  logic [2:0] out_color;
  logic [5:0] out_empty_cnt;

  modport master (
    output in_valid, in_color,
    input  in_ready, out_valid, out_color, out_empty_cnt
  );

  modport slave (
    input  in_valid, in_color,
    output in_ready, out_valid, out_color, out_empty_cnt
  );
endinterface

// File: rtl/cc_gravity.sv
// Gravity stage: load a 6x6 board, drop candies to the bottom of each column, stream it out.
// Optional refill of vacated cells from an LFSR when CC_GRAVITY_REFILL_EN is defined.
module cc_gravity #(
  parameter logic [7:0] LFSR_SEED = 8'h01
) (
  input logic         clk,
  input logic         rst,
  cc_gravity_if.slave bus
);

  localparam logic [2:0] EMPTY = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMPACT, S_OUT} state_t;

  state_t     state_q, state_d;
  logic [5:0] idx_q, idx_d;
  logic [2:0] col_q, col_d;
  logic [2:0] rd_q, rd_d;
  logic [2:0] wr_q, wr_d;
  logic [5:0] cnt_q, cnt_d;
  logic       out_valid_q, out_valid_d;
  logic [2:0] out_color_q, out_color_d;
  logic [5:0] out_cnt_q, out_cnt_d;
  logic [2:0] board_q [36];
  logic [2:0] board_d [36];

  logic       in_ready;
  logic [5:0] rd_idx, wr_idx;
  logic [2:0] cell_rd, out_cell;

  assign rd_idx   = 6'(rd_q) * 6'd6 + 6'(col_q);
  assign wr_idx   = 6'(wr_q) * 6'd6 + 6'(col_q);
  assign cell_rd  = board_q[rd_idx];
  assign out_cell = board_q[idx_q];

  // Held low through the cycle the last OUT cell is on the bus, so a new frame
  // cannot start until the previous one has fully drained.
  assign in_ready = ((state_q == S_IDLE) || (state_q == S_LOAD)) && !out_valid_q;

`ifdef CC_GRAVITY_REFILL_EN
  localparam logic [7:0] SEED = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  logic [7:0] lfsr_q, lfsr_d;
  logic [2:0] refill_color;

  assign refill_color = (lfsr_q[2:0] < 3'd6) ? lfsr_q[2:0] : lfsr_q[2:0] - 3'd6;

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= lfsr_d;
  end
`else
  logic unused_seed;
  assign unused_seed = ^LFSR_SEED;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    col_d       = col_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    out_color_d = '0;
    out_cnt_d   = '0;
    board_d     = board_q;
`ifdef CC_GRAVITY_REFILL_EN
    lfsr_d      = lfsr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid && in_ready) begin
          board_d[0] = bus.in_color;
          idx_d      = 6'd1;
          cnt_d      = '0;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        if (bus.in_valid) begin
          board_d[idx_q] = bus.in_color;
          if (idx_q == 6'd35) begin
            col_d   = '0;
            rd_d    = 3'd5;
            wr_d    = 3'd5;
            state_d = S_COMPACT;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_COMPACT: begin
        // wr never passes rd, so moving a candy down then clearing its source is safe
        if (cell_rd != EMPTY) begin
          board_d[wr_idx] = cell_rd;
          if (wr_q != rd_q) board_d[rd_idx] = EMPTY;
          wr_d = wr_q - 3'd1;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
        if (rd_q == 3'd0) begin
          rd_d = 3'd5;
          wr_d = 3'd5;
          if (col_q == 3'd5) begin
            idx_d   = '0;
            state_d = S_OUT;
          end else begin
            col_d = col_q + 3'd1;
          end
        end else begin
          rd_d = rd_q - 3'd1;
        end
      end
      S_OUT: begin
        out_valid_d = 1'b1;
        out_cnt_d   = cnt_q;
`ifdef CC_GRAVITY_REFILL_EN
        if (out_cell == EMPTY) begin
          out_color_d = refill_color;
          lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end else begin
          out_color_d = out_cell;
        end
`else
        out_color_d = out_cell;
`endif
        if (idx_q == 6'd35) state_d = S_IDLE;
        else                idx_d   = idx_q + 6'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      col_q       <= '0;
      rd_q        <= 3'd5;
      wr_q        <= 3'd5;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_color_q <= '0;
      out_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      col_q       <= col_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_color_q <= out_color_d;
      out_cnt_q   <= out_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    board_q <= board_d;
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_color     = out_color_q;
  assign bus.out_empty_cnt = out_cnt_q;

endmodule

// File: tb/tb_cc_gravity.sv
// Bench for cc_gravity: directed table of boards, abort/reset sequences, and random boards
// checked against a column-queue reference model.
module tb_cc_gravity;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cc_gravity_if bus ();

  cc_gravity #(.LFSR_SEED(8'h01)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef CC_GRAVITY_REFILL_EN
  localparam bit REFILL = 1'b1;
`else
  localparam bit REFILL = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [2:0] frm   [36];
  logic [2:0] exp_c [36];
  logic [2:0] got   [36];
  int         exp_cnt;
  logic [7:0] m_lfsr;

  typedef struct {
    string name;
    int    pattern;
    int    exp_cnt;
    int    exp0;
    int    exp1;
    int    exp6;
  } vec_t;

  vec_t tbl [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference: per column, keep surviving candies in order and stack them at the bottom.
  function automatic void build_expected();
    exp_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      logic [2:0] q [$];
      int pad;
      q = {};
      for (int r = 0; r < 6; r++) begin
        if (frm[r*6+c] == 3'd7) exp_cnt++;
        else q.push_back(frm[r*6+c]);
      end
      pad = 6 - q.size();
      for (int r = 0; r < 6; r++)
        exp_c[r*6+c] = (r < pad) ? 3'd7 : q[r-pad];
    end
    if (REFILL) begin
      for (int i = 0; i < 36; i++) begin
        if (exp_c[i] == 3'd7) begin
          int v;
          v = int'(m_lfsr) % 8;
          exp_c[i] = 3'((v < 6) ? v : v - 6);
          m_lfsr = 8'((int'(m_lfsr) * 2) % 256) | 8'(^(m_lfsr & 8'hB8));
        end
      end
    end
  endfunction

  function automatic void fill_pattern(input int p);
    for (int i = 0; i < 36; i++) frm[i] = (p == 2) ? 3'd7 : 3'(i % 6);
    if (p == 1) begin
      frm[0] = 3'd0; frm[6] = 3'd1; frm[12] = 3'd7;
      frm[18] = 3'd2; frm[24] = 3'd7; frm[30] = 3'd3;
    end
  endfunction

  task automatic do_reset(input bit check);
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_color = '0;
    @(negedge clk);
    rst = 1'b0;
    m_lfsr = 8'h01;
    if (check) begin
      chk("reset out_valid", 32'(bus.out_valid), 0);
      chk("reset out_color", 32'(bus.out_color), 0);
      chk("reset out_empty_cnt", 32'(bus.out_empty_cnt), 0);
      chk("reset in_ready", 32'(bus.in_ready), 1);
    end
  endtask

  // Drives cells starting at the current negedge; returns at the negedge after the last sample.
  task automatic drive_cells(input int n);
    chk("in_ready before frame", 32'(bus.in_ready), 1);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_color = frm[i];
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_color = '0;
  endtask

  task automatic collect(input string tag);
    int k;
    k = 0;
    while (bus.out_valid !== 1'b1 && k < 80) begin
      @(negedge clk);
      k++;
    end
    chk({tag, " latency"}, 32'(k), 37);
    if (bus.out_valid !== 1'b1) return;
    chk({tag, " in_ready during OUT"}, 32'(bus.in_ready), 0);
    for (int i = 0; i < 36; i++) begin
      got[i] = bus.out_color;
      chk($sformatf("%s cell %0d valid+color", tag, i), {28'd0, bus.out_valid, bus.out_color},
          {28'd0, 1'b1, exp_c[i]});
      chk($sformatf("%s cell %0d empty_cnt", tag, i), 32'(bus.out_empty_cnt), 32'(exp_cnt));
      @(negedge clk);
    end
    chk({tag, " out_valid after frame"}, 32'(bus.out_valid), 0);
    chk({tag, " out_empty_cnt after frame"}, 32'(bus.out_empty_cnt), 0);
    chk({tag, " in_ready after frame"}, 32'(bus.in_ready), 1);
  endtask

  task automatic watch_quiet(input string tag, input int cycles);
    int seen, lows;
    seen = 0;
    lows = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) seen++;
      if (bus.in_ready !== 1'b1) lows++;
    end
    chk({tag, " out_valid cycles"}, 32'(seen), 0);
    chk({tag, " in_ready low cycles"}, 32'(lows), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_color = '0;

    tbl[0] = '{"no_empty", 0, 0, 0, 1, 0};
`ifdef CC_GRAVITY_REFILL_EN
    tbl[1] = '{"col0_gaps", 1, 2, 1, 1, 2};
    tbl[2] = '{"all_empty", 2, 36, 1, 2, 1};
`else
    tbl[1] = '{"col0_gaps", 1, 2, 7, 1, 7};
    tbl[2] = '{"all_empty", 2, 36, 7, 7, 7};
`endif

    do_reset(1'b1);

    for (int t = 0; t < 3; t++) begin
      do_reset(1'b0);
      fill_pattern(tbl[t].pattern);
      build_expected();
      drive_cells(36);
      collect(tbl[t].name);
      chk({tbl[t].name, " hand cnt"}, 32'(exp_cnt), 32'(tbl[t].exp_cnt));
      chk({tbl[t].name, " hand idx0"}, 32'(got[0]), 32'(tbl[t].exp0));
      chk({tbl[t].name, " hand idx1"}, 32'(got[1]), 32'(tbl[t].exp1));
      chk({tbl[t].name, " hand idx6"}, 32'(got[6]), 32'(tbl[t].exp6));
    end

    // Short frame: discarded, then a full frame must still work.
    do_reset(1'b0);
    for (int i = 0; i < 36; i++) frm[i] = 3'($urandom_range(0, 7));
    drive_cells(20);
    watch_quiet("abort", 60);
    fill_pattern(1);
    build_expected();
    drive_cells(36);
    collect("after_abort");

    // Reset during OUT cycle 10.
    fill_pattern(2);
    build_expected();
    drive_cells(36);
    begin
      int k;
      k = 0;
      while (bus.out_valid !== 1'b1 && k < 80) begin
        @(negedge clk);
        k++;
      end
      chk("rst_mid_out reach OUT", 32'(k), 37);
      for (int i = 0; i < 10; i++) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m_lfsr = 8'h01;
      chk("rst_mid_out out_valid", 32'(bus.out_valid), 0);
      chk("rst_mid_out out_empty_cnt", 32'(bus.out_empty_cnt), 0);
      chk("rst_mid_out in_ready", 32'(bus.in_ready), 1);
      watch_quiet("rst_mid_out", 60);
    end

    // Random boards; the refill LFSR carries across frames, some back-to-back.
    for (int f = 0; f < 8; f++) begin
      int gap;
      for (int i = 0; i < 36; i++)
        frm[i] = ($urandom_range(0, 2) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
      build_expected();
      drive_cells(36);
      collect($sformatf("rand%0d", f));
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cc_gravity.md
# cc_gravity

Post-clear gravity stage of the Candy-Crush datapath. It receives a 6×6 board after the match/clear stage has marked crushed cells as Empty. It drops surviving candies to the bottom of each column and streams the settled board out row-major. Optionally it refills vacated cells with pseudo-random colours, so the next scan/score pass sees a full board.

## Interface
Parameters:
- `LFSR_SEED`, default 8'h01: reset value of the refill LFSR. A value of 0 is replaced by 8'h01. Used only when `CC_GRAVITY_REFILL_EN` is defined.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  board cell strobe; one cell per cycle.
- `in_color`  in  3  cell colour. 0–5 = Red, Blue, Green, Yellow, Orange, Purple; 7 = Empty.
- `in_ready`  out  1  high in IDLE and LOAD.
- `out_valid`  out  1  settled-board cell strobe.
- `out_color`  out  3  settled cell colour.
- `out_empty_cnt`  out  6  number of Empty cells in the received board (0–36).

## Operation
- Board cell order is row-major. Cell index = row*6 + col. Row 0 is the top and row 5 is the bottom. The board is stored as 36×3-bit registers.
- Only code 7 is Empty. Code 6 is treated as a candy and passed through unchanged.
- States:
  - IDLE → LOAD on `in_valid`; that cell is stored as index 0.
  - LOAD stores one cell per `in_valid` cycle. After index 35 is stored, go to COMPACT.
  - If `in_valid` is low in LOAD before 36 cells are received, the frame is discarded and the state returns to IDLE. There is no output.
  - COMPACT takes 36 cycles, columns 0..5 in order. Within a column, the read row r goes 5 down to 0, one per cycle. The write row w starts at 5 for each column.
    - If `board[r][c]` ≠ 7: write it to `board[w][c]`. If w ≠ r, set `board[r][c]` = 7. Then decrement w.
    - Otherwise increment the empty counter.
    - Relative order of candies within a column is preserved.
  - OUT takes 36 cycles. It emits indices 0..35 with `out_valid` = 1, then returns to IDLE.
- `in_valid` is ignored in COMPACT and OUT. `in_ready` = 0 in those states.
- The empty counter is 6-bit, cleared on entry to LOAD, and cannot overflow (maximum 36).
- `out_empty_cnt` holds the final count for all OUT cycles. It is 0 outside OUT.
- `out_color` is 0 whenever `out_valid` = 0.

## Timing
- Reset values: `out_valid` = 0, `out_color` = 0, `out_empty_cnt` = 0, `in_ready` = 1, state = IDLE, LFSR = `LFSR_SEED`. Board contents are don't-care.
- Reset takes priority over everything. If asserted mid-LOAD, mid-COMPACT or mid-OUT, the frame is aborted and outputs reach reset values in the cycle after the sampling edge.
- Latency: the last input cell is sampled at edge T. COMPACT runs over edges T+1..T+36. `out_valid` is first high in the cycle after edge T+37 and stays high for exactly 36 consecutive cycles.
- `in_ready` rises in the cycle after the last OUT cell. A new frame may begin on that cycle, so the minimum frame period is 109 cycles.

## Configuration
- `CC_GRAVITY_REFILL_EN` defined:
  - During OUT, each Empty cell is emitted as `lfsr[2:0]` if that value is < 6, else `lfsr[2:0]` − 6.
  - The LFSR then advances, and only on refilled cells. The update is a left shift with fb = s[7]^s[5]^s[4]^s[3] into bit 0.
  - The LFSR is not reloaded between frames; only reset reloads it.
  - `out_empty_cnt` still reports the pre-refill empty count.
- `CC_GRAVITY_REFILL_EN` not defined: Empty cells are emitted as 7. No LFSR logic is present.

## Test plan
- No Empty cells, board colour = index mod 6: output identical to input, `out_empty_cnt` = 0, first `out_valid` 37 cycles after the last input, exactly 36 valid cycles.
- Column 0 top→bottom = 0,1,7,2,7,3; all other cells full; refill off: column 0 out = 7,7,0,1,2,3, other columns unchanged, `out_empty_cnt` = 2.
- All 36 cells = 7: output is 36×7, `out_empty_cnt` = 36. Same board with refill on and seed 8'h01: first two out colours = 1, 2.
- Board from the column-0 scenario with refill on and seed 8'h01: index 0 out = 1, index 6 out = 2, all others as in the refill-off case.
- `in_valid` dropped after 20 cells: no `out_valid`, `in_ready` stays 1. A following full 36-cell frame is processed correctly.
- `rst` pulsed at OUT cycle 10: `out_valid` = 0 and `out_empty_cnt` = 0 next cycle, `in_ready` = 1, no further output until a new frame.
